// File: rtl/demux12_4_stream_if.sv
// Stream bundle for the 1-to-2 nibble demultiplexer: one producer port, two consumer slots
// and the per-slot accept counters.
interface demux12_4_stream_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic             in_sel;
  logic             a_valid;
  logic             a_ready;
  logic [3:0]       a;
  logic             b_valid;
  logic             b_ready;
  logic [3:0]       b;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  // master = producer plus both consumers; slave = the demultiplexer itself
  modport master (
    output in_valid, in_data, in_sel, a_ready, b_ready,
    input  in_ready, a_valid, a, b_valid, b, a_count, b_count
  );

  modport slave (
    input  in_valid, in_data, in_sel, a_ready, b_ready,
    output in_ready, a_valid, a, b_valid, b, a_count, b_count
  );
endinterface

// File: rtl/demux12_4_stream.sv
// 1-to-2 nibble stream demultiplexer: in_sel steers each nibble into slot A or B,
// each slot being a one-entry holding register with valid/ready and an accept counter.
module demux12_4_stream #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  demux12_4_stream_if.slave    bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t      state_reg [2];
  logic [3:0]       data_reg  [2];
  logic [CNT_W-1:0] count_reg [2];

  logic [1:0] out_ready;
  logic [1:0] slot_free;
  logic [1:0] accept;

  assign out_ready = {bus.b_ready, bus.a_ready};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      // A slot can take a nibble when empty or when its current one leaves this cycle
      assign slot_free[gi] = (state_reg[gi] == EMPTY) || out_ready[gi];
      assign accept[gi]    = bus.in_valid && slot_free[gi] && (bus.in_sel == 1'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg[gi] <= EMPTY;
          data_reg[gi]  <= 4'h0;
          count_reg[gi] <= '0;
        end else if (accept[gi]) begin
          // Load wins over a simultaneous drain, keeping the slot FULL with no bubble
          state_reg[gi] <= FULL;
          data_reg[gi]  <= bus.in_data;
          count_reg[gi] <= count_reg[gi] + CNT_W'(1);
        end else if ((state_reg[gi] == FULL) && out_ready[gi]) begin
          state_reg[gi] <= EMPTY;
        end
      end
    end
  endgenerate

  // Only the selected slot gates the producer; the other never stalls input
  assign bus.in_ready = bus.in_sel ? slot_free[1] : slot_free[0];

  assign bus.a_valid  = (state_reg[0] == FULL);
  assign bus.b_valid  = (state_reg[1] == FULL);
  assign bus.a        = data_reg[0];
  assign bus.b        = data_reg[1];
  assign bus.a_count  = count_reg[0];
  assign bus.b_count  = count_reg[1];

endmodule
